// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared func3 codes, FSM states and counter width for mem_port_sched
package mem_sched_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int CNT_W = 3;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_port_sched_if.sv
// mem_port_sched_if: synchronous memory macro port
interface mem_port_sched_if;
    logic        mem_cs;
    logic [31:0] mem_addr;
    logic [3:0]  mem_web;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport master(output mem_cs, mem_addr, mem_web, mem_wdata, input mem_rdata);
    modport slave(input mem_cs, mem_addr, mem_web, mem_wdata, output mem_rdata);
endinterface

// File: rtl/mem_port_sched_lane_align.sv
// lane_align: byte enables, store lane replication, load extraction and alignment check
module lane_align
    import mem_sched_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  web,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misalign
);
    logic [31:0] sh;
    logic        ill;
    logic        bad;
    always_comb begin
        sh        = rdata >> {addr, 3'b000};
        ill       = we ? func3 > F3_W : func3 == 3'b011 || func3[2:1] == 2'b11;
        bad       = func3[1:0] == 2'b01 ? addr[0] : func3[1:0] == 2'b10 ? addr != 2'b00 : 1'b0;
        misalign  = ill | bad;
        web       = misalign ? 4'b0000 : func3[1:0] == 2'b00 ? 4'b0001 << addr :
                    func3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_sh  = func3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                    func3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        rdata_ext = func3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                    func3 == F3_BU ? {24'b0, sh[7:0]} :
                    func3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                    func3 == F3_HU ? {16'b0, sh[15:0]} : rdata;
    end
endmodule

// File: rtl/mem_port_sched.sv
// mem_port_sched: arbitrates the unified memory port between fetch and load/store
module mem_port_sched
    import mem_sched_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [2:0]  data_func3,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_done,
    output logic        misalign,
    output logic        stall,
    mem_port_sched_if.master mem
);
    state_t st, nst;
    logic [CNT_W-1:0] cnt;
    logic        is_d, we, mis, idle, iss, resp, accept, l_mis;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rd, l_wd, l_rd;
    logic [3:0]  l_web;
    assign idle   = st == IDLE;
    assign iss    = st == ISSUE;
    assign resp   = st == RESP;
    assign accept = idle & (data_req | fetch_req);
    // In IDLE the aligner judges the incoming request; afterwards it works on the registered one
    lane_align u_align (
        .we(idle ? data_we : we),
        .func3(idle ? data_func3 : f3),
        .addr(idle ? data_addr[1:0] : addr[1:0]),
        .wdata(wdata),
        .rdata(mem.mem_rdata),
        .web(l_web),
        .wdata_sh(l_wd),
        .rdata_ext(l_rd),
        .misalign(l_mis)
    );
    always_comb begin
        nst = st;
        case (st)
            IDLE:    nst = data_req ? (l_mis ? RESP : ISSUE) : fetch_req ? ISSUE : IDLE;
            ISSUE:   nst = (is_d & we) ? RESP : WAIT;
            WAIT:    nst = cnt == CNT_W'(1) ? RESP : WAIT;
            RESP:    nst = IDLE;
            default: nst = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= IDLE;
            cnt   <= '0;
            is_d  <= 1'b0;
            we    <= 1'b0;
            mis   <= 1'b0;
            f3    <= '0;
            addr  <= '0;
            wdata <= '0;
            rd    <= '0;
        end else begin
            st <= nst;
            if (accept) begin
                is_d  <= data_req;
                we    <= data_req & data_we;
                f3    <= data_func3;
                addr  <= data_req ? data_addr : fetch_addr;
                wdata <= data_wdata;
                mis   <= data_req & l_mis;
                if (data_req & l_mis) rd <= '0;
            end
            if (iss) cnt <= CNT_W'(MEM_LAT);
            if (st == WAIT) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) rd <= is_d ? l_rd : mem.mem_rdata;
            end
        end
    end
    assign mem.mem_cs    = iss;
    assign mem.mem_addr  = iss ? {addr[31:2], 2'b00} : '0;
    assign mem.mem_web   = (iss & we) ? l_web : '0;
    assign mem.mem_wdata = (iss & we) ? l_wd : '0;
    assign instr         = rd;
    assign data_rdata    = rd;
    assign instr_valid   = resp & ~is_d;
    assign data_done     = resp & is_d;
    assign misalign      = resp & mis;
    assign stall         = (fetch_req & ~instr_valid) | (data_req & ~data_done);
endmodule

// File: tb/tb_mem_port_sched.sv
// tb_mem_port_sched: scoreboard bench for mem_port_sched at MEM_LAT=1 and MEM_LAT=3
module tb_mem_port_sched;
    typedef struct {bit isd; bit mis; bit cv; logic [31:0] v;} exp_t;
    typedef struct {logic [31:0] a; logic [3:0] w; logic [31:0] d;} cs_t;
    logic clk = 0;
    logic rst_a = 1, rst_b = 1;
    logic fetch_req_a = 0, data_req_a = 0, data_we_a = 0;
    logic [2:0]  data_func3_a = 0;
    logic [31:0] fetch_addr_a = 0, data_addr_a = 0, data_wdata_a = 0;
    logic [31:0] instr_a, data_rdata_a;
    logic instr_valid_a, data_done_a, misalign_a, stall_a;
    logic fetch_req_b = 0;
    logic [31:0] fetch_addr_b = 0;
    logic [31:0] instr_b, data_rdata_b;
    logic instr_valid_b, data_done_b, misalign_b, stall_b;
    logic [31:0] mem [256];
    logic [7:0] la_a = 0, la_b = 0;
    int total = 0, bad = 0, sbad = 0, quiet = 0;
    exp_t sq[$];
    cs_t csq[$];
    mem_port_sched_if ma();
    mem_port_sched_if mb();
    mem_port_sched #(.MEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst_a), .fetch_req(fetch_req_a), .fetch_addr(fetch_addr_a),
        .instr(instr_a), .instr_valid(instr_valid_a), .data_req(data_req_a),
        .data_we(data_we_a), .data_func3(data_func3_a), .data_addr(data_addr_a),
        .data_wdata(data_wdata_a), .data_rdata(data_rdata_a), .data_done(data_done_a),
        .misalign(misalign_a), .stall(stall_a), .mem(ma)
    );
    mem_port_sched #(.MEM_LAT(3)) dut_b (
        .clk(clk), .rst(rst_b), .fetch_req(fetch_req_b), .fetch_addr(fetch_addr_b),
        .instr(instr_b), .instr_valid(instr_valid_b), .data_req(1'b0),
        .data_we(1'b0), .data_func3(3'b000), .data_addr(32'h0),
        .data_wdata(32'h0), .data_rdata(data_rdata_b), .data_done(data_done_b),
        .misalign(misalign_b), .stall(stall_b), .mem(mb)
    );
    always #5 clk = ~clk;
    // Memory macro: latches the word address on the chip-select edge
    always @(posedge clk) begin
        if (ma.mem_cs) la_a <= ma.mem_addr[9:2];
        if (mb.mem_cs) la_b <= mb.mem_addr[9:2];
    end
    assign ma.mem_rdata = mem[la_a];
    assign mb.mem_rdata = mem[la_b];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (ma.mem_cs) csq.push_back('{ma.mem_addr, ma.mem_web, ma.mem_wdata});
        else if (ma.mem_addr != 0 || ma.mem_web != 0 || ma.mem_wdata != 0) quiet++;
        if (misalign_a & ~data_done_a) quiet++;
        if (instr_valid_a | data_done_a) begin
            if (sq.size() == 0) chk("sb empty", 1, 0);
            else begin
                e = sq.pop_front();
                chk("sb kind", {31'b0, data_done_a}, {31'b0, e.isd});
                if (e.cv) chk("sb val", data_done_a ? data_rdata_a : instr_a, e.v);
                chk("sb mis", {31'b0, misalign_a}, {31'b0, e.mis});
            end
        end
    end
    task automatic acc(input string tag, input bit isd, input bit we, input logic [2:0] f3,
                       input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] ev,
                       input bit emis, input logic [3:0] ew, input logic [31:0] ewd, input bit drop);
        int n, el;
        cs_t c;
        exp_t e;
        el = emis ? 1 : (isd & we) ? 2 : 3;
        e.isd = isd; e.mis = emis; e.cv = !(isd & we); e.v = ev;
        sq.push_back(e);
        @(negedge clk); #1;
        if (isd) begin
            data_req_a = 1; data_we_a = we; data_func3_a = f3; data_addr_a = ad; data_wdata_a = wd;
        end else begin
            fetch_req_a = 1; fetch_addr_a = ad;
        end
        n = 0;
        do begin
            @(negedge clk); #1; n++;
            if (stall_a !== ((data_req_a & ~data_done_a) | (fetch_req_a & ~instr_valid_a))) sbad++;
            if (drop && n == 1) begin
                data_req_a = 0; fetch_req_a = 0; data_addr_a = ~ad; fetch_addr_a = ~ad;
                data_func3_a = 3'b010; data_wdata_a = ~wd; data_we_a = ~we;
            end
        end while (!(instr_valid_a | data_done_a) && n < 30);
        data_req_a = 0; fetch_req_a = 0;
        chk({tag, " lat"}, n, el);
        chk({tag, " ncs"}, csq.size(), emis ? 0 : 1);
        if (csq.size() > 0) begin
            c = csq.pop_front();
            chk({tag, " addr"}, c.a, {ad[31:2], 2'b00});
            chk({tag, " web"}, {28'b0, c.w}, {28'b0, ew});
            if (we) chk({tag, " wdata"}, c.d, ewd);
        end
        csq.delete();
    endtask
    task automatic fetch_b(input string tag, input logic [31:0] ad, input logic [31:0] ev);
        int n;
        @(negedge clk); #1;
        fetch_req_b = 1; fetch_addr_b = ad;
        n = 0;
        do begin
            @(negedge clk); #1; n++;
            if (stall_b !== ~instr_valid_b) sbad++;
        end while (!instr_valid_b && n < 30);
        fetch_req_b = 0;
        chk({tag, " lat"}, n, 5);
        chk({tag, " instr"}, instr_b, ev);
    endtask
    task automatic watch_b(input string tag);
        int pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (instr_valid_b | data_done_b) pulses++;
        end
        chk({tag, " no pulse"}, pulses, 0);
    endtask
    initial begin
        int n;
        cs_t c;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h00500093;
        mem[8'h80] = 32'h00008000;
        mem[8'h81] = 32'h80017F02;
        repeat (3) @(negedge clk);
        chk("rst cs", {31'b0, ma.mem_cs}, 0);
        chk("rst addr", ma.mem_addr, 0);
        chk("rst web", {28'b0, ma.mem_web}, 0);
        chk("rst pulses", {29'b0, instr_valid_a, data_done_a, misalign_a}, 0);
        chk("rst data", instr_a | data_rdata_a, 0);
        chk("rst stall", {31'b0, stall_a}, 0);
        rst_a = 0; rst_b = 0;
        acc("fetch", 0, 0, 3'b000, 32'h100, 0, 32'h00500093, 0, 4'h0, 0, 0);
        // Simultaneous requests: data first, fetch after RESP and IDLE
        @(negedge clk); #1;
        sq.push_back('{1, 0, 1, 32'h00008000});
        sq.push_back('{0, 0, 1, 32'h00500093});
        fetch_req_a = 1; fetch_addr_a = 32'h100;
        data_req_a = 1; data_we_a = 0; data_func3_a = 3'b010; data_addr_a = 32'h200;
        n = 0;
        do begin
            @(negedge clk); #1; n++;
            if (stall_a !== ((data_req_a & ~data_done_a) | (fetch_req_a & ~instr_valid_a))) sbad++;
            if (data_done_a) begin chk("cc data lat", n, 3); data_req_a = 0; end
            if (instr_valid_a) chk("cc fetch lat", n, 7);
        end while (!instr_valid_a && n < 30);
        fetch_req_a = 0;
        chk("cc ncs", csq.size(), 2);
        if (csq.size() == 2) begin
            c = csq.pop_front(); chk("cc first addr", c.a, 32'h200);
            c = csq.pop_front(); chk("cc second addr", c.a, 32'h100);
        end
        csq.delete();
        acc("sb203", 1, 1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 4'b1000, 32'hA5A5A5A5, 0);
        acc("sb200", 1, 1, 3'b000, 32'h200, 32'h00000012, 0, 0, 4'b0001, 32'h12121212, 0);
        acc("sh202", 1, 1, 3'b001, 32'h202, 32'h1234BEEF, 0, 0, 4'b1100, 32'hBEEFBEEF, 0);
        acc("sw204", 1, 1, 3'b010, 32'h204, 32'hDEADBEEF, 0, 0, 4'b1111, 32'hDEADBEEF, 0);
        acc("lb201", 1, 0, 3'b000, 32'h201, 0, 32'hFFFFFF80, 0, 4'h0, 0, 0);
        acc("lbu201", 1, 0, 3'b100, 32'h201, 0, 32'h00000080, 0, 4'h0, 0, 0);
        acc("lh206", 1, 0, 3'b001, 32'h206, 0, 32'hFFFF8001, 0, 4'h0, 0, 0);
        acc("lhu206", 1, 0, 3'b101, 32'h206, 0, 32'h00008001, 0, 4'h0, 0, 0);
        acc("lb205", 1, 0, 3'b000, 32'h205, 0, 32'h0000007F, 0, 4'h0, 0, 0);
        acc("lw204", 1, 0, 3'b010, 32'h204, 0, 32'h80017F02, 0, 4'h0, 0, 0);
        acc("sh201", 1, 1, 3'b001, 32'h201, 32'h1234, 0, 1, 4'h0, 0, 0);
        acc("lw202", 1, 0, 3'b010, 32'h202, 0, 0, 1, 4'h0, 0, 0);
        acc("lh203", 1, 0, 3'b001, 32'h203, 0, 0, 1, 4'h0, 0, 0);
        acc("sw202", 1, 1, 3'b010, 32'h202, 32'h55, 0, 1, 4'h0, 0, 0);
        acc("ld f3=3", 1, 0, 3'b011, 32'h200, 0, 0, 1, 4'h0, 0, 0);
        acc("ld f3=6", 1, 0, 3'b110, 32'h200, 0, 0, 1, 4'h0, 0, 0);
        acc("st f3=4", 1, 1, 3'b100, 32'h200, 32'h77, 0, 1, 4'h0, 0, 0);
        acc("lbu drop", 1, 0, 3'b100, 32'h201, 0, 32'h00000080, 0, 4'h0, 0, 1);
        acc("fetch drop", 0, 0, 3'b000, 32'h100, 0, 32'h00500093, 0, 4'h0, 0, 1);
        fetch_b("b fetch", 32'h100, 32'h00500093);
        @(negedge clk); #1;
        fetch_req_b = 1; fetch_addr_b = 32'h100;
        repeat (2) @(negedge clk);
        #1 rst_b = 1; fetch_req_b = 0;
        #1;
        chk("b wait rst instr", instr_b, 0);
        chk("b wait rst outs", {29'b0, mb.mem_cs, instr_valid_b, stall_b}, 0);
        @(negedge clk); rst_b = 0;
        watch_b("b wait rst");
        @(negedge clk); #1;
        fetch_req_b = 1; fetch_addr_b = 32'h204;
        @(negedge clk); #1;
        chk("b issue cs", {31'b0, mb.mem_cs}, 1);
        rst_b = 1; fetch_req_b = 0;
        #1;
        chk("b issue rst cs", {31'b0, mb.mem_cs}, 0);
        chk("b issue rst addr", mb.mem_addr, 0);
        @(negedge clk); rst_b = 0;
        watch_b("b issue rst");
        fetch_b("b refetch", 32'h204, 32'h80017F02);
        repeat (3) @(negedge clk);
        chk("sb left", sq.size(), 0);
        chk("quiet", quiet, 0);
        chk("stall", sbad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
